// File: rtl/ccl_pkg.sv
// rtl/ccl_pkg.sv - shared state encoding and label constants for the connected-components labeler
package ccl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, RESOLVE, DONE} ccl_state_e;

  localparam int LABEL_W_DEF = 8;
  typedef logic [LABEL_W_DEF-1:0] label_t;

  localparam int BG_LABEL = 0;

endpackage

// File: rtl/ccl_label_select.sv
// rtl/ccl_label_select.sv - combinational label decision from the causal neighbourhood A B C / D p
module ccl_label_select
  import ccl_pkg::*;
#(
  parameter int LABEL_W    = 8,
  parameter int MAX_LABELS = 255
) (
  input  logic [LABEL_W-1:0] A,
  input  logic [LABEL_W-1:0] B,
  input  logic [LABEL_W-1:0] C,
  input  logic [LABEL_W-1:0] D,
  input  logic [LABEL_W-1:0] data,
  input  logic [LABEL_W:0]   num_labels,
  output logic               is_new,
  output logic               is_merge,
  output logic [LABEL_W-1:0] label,
  output logic [LABEL_W-1:0] min_label,
  output logic [LABEL_W-1:0] max_label
);

  localparam logic [LABEL_W:0]   MAX_NUM = MAX_LABELS[LABEL_W:0];
  localparam logic [LABEL_W-1:0] MAX_LBL = MAX_LABELS[LABEL_W-1:0];

  logic [3:0][LABEL_W-1:0] nb;
  logic                    fg;
  logic                    any_nb;

  assign nb = {D, C, B, A};
  assign fg = (data != '0);

  always_comb begin
    min_label = '1;
    max_label = '0;
    any_nb    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (nb[i] != LABEL_W'(BG_LABEL)) begin
        any_nb = 1'b1;
        if (nb[i] < min_label) min_label = nb[i];
        if (nb[i] > max_label) max_label = nb[i];
      end
    end
    if (!any_nb) min_label = '0;
  end

  assign is_new   = fg && !any_nb;
  assign is_merge = fg && any_nb && (min_label != max_label);

  // An exhausted allocator still labels the pixel, with the last allocatable label.
  always_comb begin
    label = '0;
    if (fg) begin
      if (!any_nb) label = (num_labels > MAX_NUM) ? MAX_LBL : num_labels[LABEL_W-1:0];
      else         label = min_label;
    end
  end

endmodule

// File: rtl/ccl_labeler.sv
// rtl/ccl_labeler.sv - single-pass connected-components labeler: FSM, allocator, merge table, resolve and lookup
module ccl_labeler
  import ccl_pkg::*;
#(
  parameter int LABEL_W    = 8,
  parameter int MAX_LABELS = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sof,
  input  logic               en,
  input  logic [LABEL_W-1:0] A,
  input  logic [LABEL_W-1:0] B,
  input  logic [LABEL_W-1:0] C,
  input  logic [LABEL_W-1:0] D,
  input  logic [LABEL_W-1:0] data,
  input  logic               eof,
  output logic [LABEL_W-1:0] q,
  output logic               q_valid,
  output logic               overflow,
  input  logic [LABEL_W-1:0] rd_label,
  output logic [LABEL_W-1:0] rd_root,
  output logic               done
);

  localparam int               DEPTH   = MAX_LABELS + 1;
  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LABEL_W:0] MAX_NUM = MAX_LABELS[LABEL_W:0];
  localparam logic [LABEL_W:0] NUM_ONE = {{LABEL_W{1'b0}}, 1'b1};

  ccl_state_e         state_q;
  logic [LABEL_W:0]   num_q, num_d, idx_q;
  logic [LABEL_W-1:0] tbl_q [DEPTH];
  logic [LABEL_W-1:0] q_q, rd_root_q;
  logic               q_valid_q, overflow_q, done_q;

  logic               is_new, is_merge, pix, alloc, alt_we;
  logic [LABEL_W-1:0] sel_label, mn, mx, old_root, nw_root, alt_addr;

  function automatic logic [AW-1:0] ta(input logic [LABEL_W-1:0] l);
    return l[AW-1:0];
  endfunction

  ccl_label_select #(
    .LABEL_W    (LABEL_W),
    .MAX_LABELS (MAX_LABELS)
  ) u_select (
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .data       (data),
    .num_labels (num_q),
    .is_new     (is_new),
    .is_merge   (is_merge),
    .label      (sel_label),
    .min_label  (mn),
    .max_label  (mx)
  );

  assign pix   = en && (state_q == RUN) && !sof;
  assign alloc = pix && is_new && (num_q <= MAX_NUM);
  assign num_d = num_q + {{LABEL_W{1'b0}}, alloc};

  // Second write re-points the old root of mx, so both former roots share the new minimum.
  always_comb begin
    old_root = tbl_q[ta(mx)];
    nw_root  = (old_root < mn) ? old_root : mn;
    alt_addr = (old_root > mn) ? old_root : mn;
    alt_we   = (old_root != mx) && (old_root != nw_root);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      num_q      <= NUM_ONE;
      idx_q      <= NUM_ONE;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      rd_root_q  <= '0;
      tbl_q[0]   <= '0;
    end else begin
      q_valid_q <= pix;
      q_q       <= pix ? sel_label : '0;
      rd_root_q <= '0;
      if (sof) begin
        state_q    <= RUN;
        num_q      <= NUM_ONE;
        overflow_q <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (pix) begin
              num_q <= num_d;
              if (alloc) begin
                tbl_q[ta(num_q[LABEL_W-1:0])] <= num_q[LABEL_W-1:0];
              end else if (is_new) begin
                overflow_q <= 1'b1;
              end else if (is_merge) begin
                tbl_q[ta(mx)] <= nw_root;
                if (alt_we) tbl_q[ta(alt_addr)] <= nw_root;
              end
              if (eof) begin
                idx_q <= NUM_ONE;
                if (num_d == NUM_ONE) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= RESOLVE;
                end
              end
            end
          end
          RESOLVE: begin
            // Entries below idx are already roots, so one lookup flattens each entry.
            tbl_q[ta(idx_q[LABEL_W-1:0])] <= tbl_q[ta(tbl_q[ta(idx_q[LABEL_W-1:0])])];
            idx_q <= idx_q + NUM_ONE;
            if (idx_q == num_q - NUM_ONE) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          DONE: begin
            if (rd_label != '0 && {1'b0, rd_label} < num_q) rd_root_q <= tbl_q[ta(rd_label)];
          end
          default: ;
        endcase
      end
    end
  end

  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign overflow = overflow_q;
  assign rd_root  = rd_root_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ccl_labeler.sv
// tb/tb_ccl_labeler.sv - directed self-checking bench for ccl_labeler with a three-label allocator
module tb_ccl_labeler;

  localparam int LW   = 8;
  localparam int MAXL = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sof = 1'b0;
  logic          en = 1'b0;
  logic          eof = 1'b0;
  logic [LW-1:0] A = '0, B = '0, C = '0, D = '0, data = '0, rd_label = '0;
  logic [LW-1:0] q, rd_root;
  logic          q_valid, overflow, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ccl_labeler #(
    .LABEL_W    (LW),
    .MAX_LABELS (MAXL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sof      (sof),
    .en       (en),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .data     (data),
    .eof      (eof),
    .q        (q),
    .q_valid  (q_valid),
    .overflow (overflow),
    .rd_label (rd_label),
    .rd_root  (rd_root),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic pixel(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic [LW-1:0] c,
                       input logic [LW-1:0] d, input logic fg, input logic last);
    en = 1'b1; A = a; B = b; C = c; D = d; data = {{(LW-1){1'b0}}, fg}; eof = last;
    tick();
    en = 1'b0; A = '0; B = '0; C = '0; D = '0; data = '0; eof = 1'b0;
  endtask

  task automatic lookup(input logic [LW-1:0] l);
    rd_label = l;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (q !== 8'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_q_valid got=%0b exp=0", q_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (rd_root !== 8'd0) begin failures++; $display("FAIL reset_rd_root got=%0d exp=0", rd_root); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pixel();
    start_frame();
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd1) begin failures++; $display("FAIL single_q got=%0d exp=1", q); end
    checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL single_q_valid got=%0b exp=1", q_valid); end
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd2) begin failures++; $display("FAIL single_next_label got=%0d exp=2", q); end
    pixel(0, 0, 0, 0, 1'b0, 1'b1);
    checks++; if (q !== 8'd0 || q_valid !== 1'b1) begin failures++; $display("FAIL single_bg q=%0d v=%0b exp q=0 v=1", q, q_valid); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_early got=%0b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done got=%0b exp=1", done); end
  endtask

  task automatic test_merge();
    start_frame();
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 1, 0, 2, 1'b1, 1'b1);
    checks++; if (q !== 8'd1 || q_valid !== 1'b1) begin failures++; $display("FAIL merge_q q=%0d v=%0b exp q=1 v=1", q, q_valid); end
    tick();
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL merge_done got=%0b exp=1", done); end
    lookup(2);
    checks++; if (rd_root !== 8'd1) begin failures++; $display("FAIL merge_root2 got=%0d exp=1", rd_root); end
    lookup(1);
    checks++; if (rd_root !== 8'd1) begin failures++; $display("FAIL merge_root1 got=%0d exp=1", rd_root); end
    lookup(0);
    checks++; if (rd_root !== 8'd0) begin failures++; $display("FAIL merge_root0 got=%0d exp=0", rd_root); end
    lookup(3);
    checks++; if (rd_root !== 8'd0) begin failures++; $display("FAIL merge_root_oob got=%0d exp=0", rd_root); end
  endtask

  task automatic test_chain();
    start_frame();
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd3) begin failures++; $display("FAIL chain_alloc3 got=%0d exp=3", q); end
    pixel(2, 0, 3, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd2) begin failures++; $display("FAIL chain_merge32 got=%0d exp=2", q); end
    pixel(0, 1, 0, 2, 1'b1, 1'b1);
    checks++; if (q !== 8'd1) begin failures++; $display("FAIL chain_merge21 got=%0d exp=1", q); end
    tick();
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL chain_done_early got=%0b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL chain_done got=%0b exp=1", done); end
    lookup(3);
    checks++; if (rd_root !== 8'd1) begin failures++; $display("FAIL chain_root3 got=%0d exp=1", rd_root); end
    lookup(2);
    checks++; if (rd_root !== 8'd1) begin failures++; $display("FAIL chain_root2 got=%0d exp=1", rd_root); end
  endtask

  task automatic test_second_write();
    start_frame();
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 2, 0, 3, 1'b1, 1'b0);
    pixel(1, 0, 3, 0, 1'b1, 1'b1);
    checks++; if (q !== 8'd1) begin failures++; $display("FAIL dual_q got=%0d exp=1", q); end
    tick();
    tick();
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL dual_done got=%0b exp=1", done); end
    lookup(2);
    checks++; if (rd_root !== 8'd1) begin failures++; $display("FAIL dual_root2 got=%0d exp=1", rd_root); end
    lookup(3);
    checks++; if (rd_root !== 8'd1) begin failures++; $display("FAIL dual_root3 got=%0d exp=1", rd_root); end
  endtask

  task automatic test_overflow();
    start_frame();
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", overflow); end
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd3) begin failures++; $display("FAIL ovf_q got=%0d exp=3", q); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
    pixel(3, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd3 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky q=%0d ovf=%0b exp q=3 ovf=1", q, overflow); end
    start_frame();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd1) begin failures++; $display("FAIL ovf_restart got=%0d exp=1", q); end
  endtask

  task automatic test_reset_in_resolve();
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    pixel(0, 0, 0, 0, 1'b1, 1'b1);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (done !== 1'b0 || q_valid !== 1'b0) begin failures++; $display("FAIL rst_resolve done=%0b v=%0b exp 0 0", done, q_valid); end
    rd_label = 8'd1;
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL idle_pixel_ignored got=%0b exp=0", q_valid); end
    tick();
    tick();
    tick();
    checks++; if (done !== 1'b0 || rd_root !== 8'd0) begin failures++; $display("FAIL rst_hold done=%0b root=%0d exp 0 0", done, rd_root); end
    start_frame();
    pixel(0, 0, 0, 0, 1'b1, 1'b1);
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rst_frame_done got=%0b exp=1", done); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (done !== 1'b0 || rd_root !== 8'd0) begin failures++; $display("FAIL rst_done done=%0b root=%0d exp 0 0", done, rd_root); end
    rd_label = 8'd0;
  endtask

  task automatic test_back_to_back();
    start_frame();
    tick();
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL gap_valid got=%0b exp=0", q_valid); end
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd1) begin failures++; $display("FAIL gap_first got=%0d exp=1", q); end
    tick();
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL gap_valid2 got=%0b exp=0", q_valid); end
    pixel(1, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd1) begin failures++; $display("FAIL gap_copy got=%0d exp=1", q); end
    pixel(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL gap_done got=%0b exp=1", done); end
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL done_pixel_ignored got=%0b exp=0", q_valid); end
    start_frame();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL sof_in_done got=%0b exp=0", done); end
    tick();
    pixel(0, 0, 0, 0, 1'b1, 1'b0);
    checks++; if (q !== 8'd1) begin failures++; $display("FAIL new_frame_first got=%0d exp=1", q); end
  endtask

  task automatic test_empty_frame();
    start_frame();
    pixel(0, 0, 0, 0, 1'b0, 1'b1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL empty_done got=%0b exp=1", done); end
    lookup(1);
    checks++; if (rd_root !== 8'd0) begin failures++; $display("FAIL empty_root got=%0d exp=0", rd_root); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_merge();
    test_chain();
    test_second_write();
    test_overflow();
    test_reset_in_resolve();
    test_back_to_back();
    test_empty_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
